// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch-side bus of the PC stage; PC_RETURN_STACK_EN adds call/ret/stack_err
`ifndef DATA_WIDTH
`define DATA_WIDTH 21
`endif

interface pc_sequencer_if #(
  parameter int ADDR_WIDTH = `DATA_WIDTH
);
  logic                  stall;
  logic                  load;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  valid;
  logic                  pending;
`ifdef PC_RETURN_STACK_EN
  logic                  call;
  logic                  ret;
  logic                  stack_err;

  modport master (output stall, load, target, call, ret,
                  input  pc, valid, pending, stack_err);
  modport slave  (input  stall, load, target, call, ret,
                  output pc, valid, pending, stack_err);
`else
  modport master (output stall, load, target,
                  input  pc, valid, pending);
  modport slave  (input  stall, load, target,
                  output pc, valid, pending);
`endif
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with branch redirect bubble, stall and pending-redirect capture
// Optional return stack enabled by PC_RETURN_STACK_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 21
`endif

module pc_sequencer #(
  parameter int                    ADDR_WIDTH   = `DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    STACK_DEPTH  = 4
) (
  input  logic           clock,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {BOOT, RUN, REDIRECT} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  valid_q;
  logic                  pending_q;
  logic [ADDR_WIDTH-1:0] pend_tgt;

  logic                  live_req;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] exec_tgt;

  assign bus.pc      = pc_q;
  assign bus.valid   = valid_q;
  assign bus.pending = pending_q;

`ifdef PC_RETURN_STACK_EN
  typedef enum logic [1:0] {OP_LOAD, OP_CALL, OP_RET} op_t;
  localparam int CW = $clog2(STACK_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] stk [STACK_DEPTH];
  logic [CW-1:0]         depth;
  logic                  stack_err_q;
  op_t                   pend_op;
  op_t                   live_op;
  op_t                   exec_op;

  assign bus.stack_err = stack_err_q;

  always_comb begin
    live_req = bus.load | bus.call | bus.ret;
    live_op  = bus.ret ? OP_RET : (bus.call ? OP_CALL : OP_LOAD);
    exec_op  = live_req ? live_op : pend_op;
    redirect = live_req | pending_q;
    exec_tgt = live_req ? bus.target : pend_tgt;
    // Popping an empty stack falls back to the reset vector
    if (exec_op == OP_RET)
      exec_tgt = (depth == '0) ? RESET_VECTOR : stk[0];
  end
`else
  always_comb begin
    live_req = bus.load;
    redirect = live_req | pending_q;
    exec_tgt = live_req ? bus.target : pend_tgt;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= BOOT;
      pc_q      <= RESET_VECTOR;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
      pend_tgt  <= '0;
`ifdef PC_RETURN_STACK_EN
      pend_op     <= OP_LOAD;
      depth       <= '0;
      stack_err_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
`endif
    end else if (bus.stall) begin
      // Everything freezes except capture of a redirect; last request wins
      if (live_req) begin
        pending_q <= 1'b1;
        pend_tgt  <= bus.target;
`ifdef PC_RETURN_STACK_EN
        pend_op   <= live_op;
`endif
      end
    end else begin
      case (state)
        BOOT: begin
          state   <= RUN;
          valid_q <= 1'b1;
        end
        default: begin
          if (redirect) begin
            pc_q      <= exec_tgt;
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
            state     <= REDIRECT;
`ifdef PC_RETURN_STACK_EN
            // Stack is a shift register with stk[0] on top; a full push drops the bottom
            if (exec_op == OP_CALL) begin
              for (int i = STACK_DEPTH - 1; i > 0; i--) stk[i] <= stk[i-1];
              stk[0] <= pc_q + ADDR_WIDTH'(1);
              if (depth == CW'(STACK_DEPTH)) stack_err_q <= 1'b1;
              else                           depth       <= depth + CW'(1);
            end else if (exec_op == OP_RET) begin
              if (depth == '0) begin
                stack_err_q <= 1'b1;
              end else begin
                for (int i = 0; i < STACK_DEPTH - 1; i++) stk[i] <= stk[i+1];
                depth <= depth - CW'(1);
              end
            end
`endif
          end else if (state == RUN) begin
            pc_q    <= pc_q + ADDR_WIDTH'(1);
            valid_q <= 1'b1;
          end else begin
            valid_q <= 1'b1;
            state   <= RUN;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
  logic clock = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  pc_sequencer_if #(.ADDR_WIDTH(21)) bus ();

  pc_sequencer #(.ADDR_WIDTH(21)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [31:0] pc, input logic v, input logic p);
    chk({tag, "_pc"}, bus.pc, pc);
    chk({tag, "_valid"}, bus.valid, v);
    chk({tag, "_pending"}, bus.pending, p);
  endtask

  initial begin
    reset      = 1'b1;
    bus.stall  = 1'b0;
    bus.load   = 1'b0;
    bus.target = '0;
`ifdef PC_RETURN_STACK_EN
    bus.call = 1'b0;
    bus.ret  = 1'b0;
`endif
    tick(); tick(); tick();
    chk3("reset", 32'h0, 1'b0, 1'b0);

    // boot cycle then sequential fetch from 0
    reset = 1'b0;
    tick(); chk3("boot_exit", 32'h0, 1'b1, 1'b0);
    tick(); chk3("run1", 32'h1, 1'b1, 1'b0);
    tick(); chk3("run2", 32'h2, 1'b1, 1'b0);
    tick(); chk3("run3", 32'h3, 1'b1, 1'b0);
    tick(); tick(); chk3("run5", 32'h5, 1'b1, 1'b0);

    // taken branch at PC=5
    bus.load = 1'b1; bus.target = 21'h00ABCD;
    tick(); chk3("br_target", 32'hABCD, 1'b0, 1'b0);
    bus.load = 1'b0;
    tick(); chk3("br_bubble_end", 32'hABCD, 1'b1, 1'b0);
    tick(); chk3("br_incr", 32'hABCE, 1'b1, 1'b0);

    // move to PC=10 then stall with two loads, last wins
    bus.load = 1'b1; bus.target = 21'h00000A;
    tick(); bus.load = 1'b0;
    tick(); chk3("at10", 32'hA, 1'b1, 1'b0);
    bus.stall = 1'b1; bus.load = 1'b1; bus.target = 21'h000100;
    tick(); chk3("stall1", 32'hA, 1'b1, 1'b1);
    bus.target = 21'h000200;
    tick(); chk3("stall2", 32'hA, 1'b1, 1'b1);
    bus.load = 1'b0;
    tick(); tick(); chk3("stall4", 32'hA, 1'b1, 1'b1);
    bus.stall = 1'b0;
    tick(); chk3("stall_rel", 32'h200, 1'b0, 1'b0);
    tick(); chk3("stall_rel_v", 32'h200, 1'b1, 1'b0);
    tick(); chk3("stall_rel_inc", 32'h201, 1'b1, 1'b0);

    // increment wraps modulo 2^21
    bus.load = 1'b1; bus.target = 21'h1FFFFE;
    tick(); bus.load = 1'b0;
    tick(); chk3("wrap_fe", 32'h1FFFFE, 1'b1, 1'b0);
    tick(); chk3("wrap_ff", 32'h1FFFFF, 1'b1, 1'b0);
    tick(); chk3("wrap_00", 32'h0, 1'b1, 1'b0);

    // load during REDIRECT overrides
    bus.load = 1'b1; bus.target = 21'h000300;
    tick(); bus.target = 21'h000400;
    tick(); chk3("redir_override", 32'h400, 1'b0, 1'b0);
    bus.load = 1'b0;
    tick(); chk3("redir_override_v", 32'h400, 1'b1, 1'b0);

    // stall during REDIRECT keeps the bubble
    bus.load = 1'b1; bus.target = 21'h000500;
    tick(); bus.load = 1'b0; bus.stall = 1'b1;
    tick(); chk3("redir_stall", 32'h500, 1'b0, 1'b0);
    bus.stall = 1'b0;
    tick(); chk3("redir_stall_rel", 32'h500, 1'b1, 1'b0);

    // pending redirect loses to a simultaneous load on release
    bus.stall = 1'b1; bus.load = 1'b1; bus.target = 21'h000600;
    tick(); chk3("pend_cap", 32'h500, 1'b1, 1'b1);
    bus.stall = 1'b0; bus.target = 21'h000700;
    tick(); chk3("pend_vs_load", 32'h700, 1'b0, 1'b0);
    bus.load = 1'b0;
    tick(); chk3("pend_vs_load_v", 32'h700, 1'b1, 1'b0);

    // reset in REDIRECT with a pending capture discards everything
    bus.load = 1'b1; bus.target = 21'h000800;
    tick(); bus.stall = 1'b1; bus.target = 21'h000900;
    tick(); chk3("pre_reset", 32'h800, 1'b0, 1'b1);
    reset = 1'b1;
    tick(); chk3("mid_reset", 32'h0, 1'b0, 1'b0);
    reset = 1'b0; bus.stall = 1'b0; bus.load = 1'b0;
    tick(); chk3("post_reset_boot", 32'h0, 1'b1, 1'b0);
    tick(); chk3("post_reset_run", 32'h1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
